pe_array_sink: RTL and testbench

Output-side collector for the systolic PE array (chain of `cpu_6502` processing elements). It receives the last stage's `Vld`/`Xout`/`Yout` stream and packs each sample into a byte, `{Yout, Xout}`. Two bytes form one 16-bit word, which is buffered in a small FIFO. Words leave on a valid/ready port toward the host or SystemC bench, so the array output no longer has to be sampled cycle-exactly.

---
 rtl/pe_array_sink.sv | 146 ++++++++++++++
 tb/tb_pe_array_sink.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pe_array_sink.sv
// Output collector for the systolic PE array: packs {Yin,Xin} sample pairs into
// 16-bit words and buffers them in a first-word-fall-through FIFO with a valid/ready read port.
module pe_array_sink #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Vld,
  input  logic [3:0]               Xin,
  input  logic [3:0]               Yin,
  input  logic                     Flush,
  output logic [15:0]              Dout,
  output logic                     Dout_Vld,
  input  logic                     Dout_Rdy,
  output logic                     Ovf,
  output logic [$clog2(DEPTH):0]   Level,
  output logic [CNT_W-1:0]         SampleCnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {HALF_LO = 1'b0, HALF_HI = 1'b1} half_t;

  half_t             half_r;
  logic [7:0]        lo_r;
  logic [15:0]       mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic [15:0]       head_r;
  logic              vld_r;
  logic              ovf_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [7:0]        byte_s;
  logic              push_s;
  logic [15:0]       word_s;
  half_t             half_nxt_s;
  logic [7:0]        lo_nxt_s;
  logic              full_s;
  logic              pop_s;
  logic              wr_en_s;
  logic              drop_s;
  logic [AW-1:0]     rd_nxt_s;
  logic [AW-1:0]     wr_nxt_s;
  logic [AW:0]       count_nxt_s;
  logic [15:0]       head_nxt_s;

  // Packer next state: pair bytes into words, honour flush of a pending half word
  always_comb begin
    byte_s     = {Yin, Xin};
    push_s     = 1'b0;
    word_s     = 16'h0000;
    half_nxt_s = half_r;
    lo_nxt_s   = lo_r;
    case (half_r)
      HALF_LO: begin
        if (Vld && Flush) begin
          push_s = 1'b1;
          word_s = {8'h00, byte_s};
        end else if (Vld) begin
          lo_nxt_s   = byte_s;
          half_nxt_s = HALF_HI;
        end else begin
          half_nxt_s = HALF_LO;
        end
      end
      HALF_HI: begin
        if (Vld) begin
          push_s     = 1'b1;
          word_s     = {byte_s, lo_r};
          half_nxt_s = HALF_LO;
        end else if (Flush) begin
          push_s     = 1'b1;
          word_s     = {8'h00, lo_r};
          half_nxt_s = HALF_LO;
        end else begin
          half_nxt_s = HALF_HI;
        end
      end
      default: begin
        half_nxt_s = HALF_LO;
      end
    endcase
  end

  // FIFO control; the head word is precomputed so Dout can be a register
  always_comb begin
    full_s      = (count_r == (AW+1)'(DEPTH));
    pop_s       = (count_r != {(AW+1){1'b0}}) && Dout_Rdy;
    wr_en_s     = push_s && (!full_s || pop_s);
    drop_s      = push_s && full_s && !pop_s;
    rd_nxt_s    = pop_s   ? rd_ptr_r + AW'(1) : rd_ptr_r;
    wr_nxt_s    = wr_en_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
    count_nxt_s = count_r + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);
    // the next head is the incoming word only when it lands in the slot the read pointer moves to
    if (wr_en_s && (wr_ptr_r == rd_nxt_s)) begin
      head_nxt_s = word_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Packer state, FIFO storage, pointers and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_r   <= HALF_LO;
      lo_r     <= 8'h00;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      head_r   <= 16'h0000;
      vld_r    <= 1'b0;
      ovf_r    <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else begin
      half_r   <= half_nxt_s;
      lo_r     <= lo_nxt_s;
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      count_r  <= count_nxt_s;
      head_r   <= head_nxt_s;
      vld_r    <= (count_nxt_s != {(AW+1){1'b0}});
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= word_s;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
      if (Vld) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign Dout      = head_r;
  assign Dout_Vld  = vld_r;
  assign Ovf       = ovf_r;
  assign Level     = count_r;
  assign SampleCnt = cnt_r;

endmodule

// File: tb/tb_pe_array_sink.sv
// Directed bench for pe_array_sink: expected words go into a scoreboard queue,
// a negedge monitor pops and compares each word the DUT hands out.
module tb_pe_array_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Vld = 1'b0;
  logic [3:0]  Xin = 4'h0;
  logic [3:0]  Yin = 4'h0;
  logic        Flush = 1'b0;
  logic        Dout_Rdy = 1'b0;
  logic [15:0] Dout;
  logic        Dout_Vld;
  logic        Ovf;
  logic [3:0]  Level;
  logic [15:0] SampleCnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  pe_array_sink #(.DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Vld(Vld), .Xin(Xin), .Yin(Yin), .Flush(Flush),
    .Dout(Dout), .Dout_Vld(Dout_Vld), .Dout_Rdy(Dout_Rdy), .Ovf(Ovf),
    .Level(Level), .SampleCnt(SampleCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // inputs are held across the next rising edge, then control returns 1 time unit after it
  task automatic step(input logic v, input logic [3:0] x, input logic [3:0] y,
                      input logic f, input logic r);
    Vld = v; Xin = x; Yin = y; Flush = f; Dout_Rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic sample_byte(input logic [7:0] b, input logic r);
    step(1'b1, b[3:0], b[7:4], 1'b0, r);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 4'h0, 4'h0, 1'b0, r);
  endtask

  // monitor: a word is consumed at the next edge whenever valid and ready are both seen here
  always @(negedge clk) begin
    if (!reset && Dout_Vld && Dout_Rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", Dout);
      end else begin
        chk("dout_word", {16'h0000, Dout}, {16'h0000, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] b;
    #1 reset = 1'b1;
    #1;
    chk("rst_dout", {16'h0000, Dout}, 32'h0);
    chk("rst_vld", {31'h0, Dout_Vld}, 32'h0);
    chk("rst_level", {28'h0, Level}, 32'h0);
    chk("rst_cnt", {16'h0, SampleCnt}, 32'h0);
    chk("rst_ovf", {31'h0, Ovf}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // basic packing
    exp_q.push_back(16'h4321);
    exp_q.push_back(16'h8765);
    step(1'b1, 4'h1, 4'h2, 1'b0, 1'b0);
    step(1'b1, 4'h3, 4'h4, 1'b0, 1'b0);
    step(1'b1, 4'h5, 4'h6, 1'b0, 1'b0);
    step(1'b1, 4'h7, 4'h8, 1'b0, 1'b0);
    chk("basic_level", {28'h0, Level}, 32'd2);
    chk("basic_cnt", {16'h0, SampleCnt}, 32'd4);
    chk("basic_head", {16'h0, Dout}, 32'h4321);
    chk("basic_vld", {31'h0, Dout_Vld}, 32'h1);
    idle(1'b1);
    chk("basic_head_after_pop", {16'h0, Dout}, 32'h8765);
    idle(1'b1);
    idle(1'b0);
    chk("basic_drained", {28'h0, Level}, 32'd0);

    // flush of a pending half word, then a flush with nothing pending
    exp_q.push_back(16'hDCBA);
    exp_q.push_back(16'h00FE);
    step(1'b1, 4'hA, 4'hB, 1'b0, 1'b0);
    step(1'b1, 4'hC, 4'hD, 1'b0, 1'b0);
    step(1'b1, 4'hE, 4'hF, 1'b0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("flush_level", {28'h0, Level}, 32'd2);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    chk("flush_drained", {28'h0, Level}, 32'd0);

    // flush merged with a sample in HALF=0
    exp_q.push_back(16'h0019);
    step(1'b1, 4'h9, 4'h1, 1'b1, 1'b0);
    chk("merge_level", {28'h0, Level}, 32'd1);
    idle(1'b1);
    idle(1'b0);
    chk("merge_cnt", {16'h0, SampleCnt}, 32'd8);

    // overflow: 18 samples into an 8-word FIFO, the 9th word is dropped
    for (int k = 0; k < 8; k++) exp_q.push_back({8'(2*k+1), 8'(2*k)});
    for (int i = 0; i < 18; i++) begin
      sample_byte(8'(i), 1'b0);
      if (i == 15) begin
        chk("ovf_full_level", {28'h0, Level}, 32'd8);
        chk("ovf_not_yet", {31'h0, Ovf}, 32'h0);
      end
    end
    chk("ovf_set", {31'h0, Ovf}, 32'h1);
    chk("ovf_level", {28'h0, Level}, 32'd8);
    chk("ovf_cnt", {16'h0, SampleCnt}, 32'd26);
    for (int i = 0; i < 8; i++) idle(1'b1);
    idle(1'b0);
    chk("ovf_drained", {28'h0, Level}, 32'd0);
    chk("ovf_sticky", {31'h0, Ovf}, 32'h1);

    // reset mid-word: 2 words plus a pending byte are discarded
    for (int i = 0; i < 5; i++) sample_byte(8'h30 + 8'(i), 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_dout", {16'h0, Dout}, 32'h0);
    chk("mid_rst_vld", {31'h0, Dout_Vld}, 32'h0);
    chk("mid_rst_level", {28'h0, Level}, 32'd0);
    chk("mid_rst_cnt", {16'h0, SampleCnt}, 32'd0);
    chk("mid_rst_ovf", {31'h0, Ovf}, 32'h0);
    reset = 1'b0;
    exp_q.push_back(16'h6655);
    sample_byte(8'h55, 1'b0);
    sample_byte(8'h66, 1'b0);
    chk("post_rst_level", {28'h0, Level}, 32'd1);
    chk("post_rst_cnt", {16'h0, SampleCnt}, 32'd2);
    idle(1'b1);
    idle(1'b0);

    // full FIFO with a pop in the same cycle as a completing word
    for (int k = 0; k < 8; k++) exp_q.push_back({8'h81 + 8'(2*k), 8'h80 + 8'(2*k)});
    exp_q.push_back(16'h9190);
    for (int i = 0; i < 16; i++) begin
      b = 8'h80 + 8'(i);
      sample_byte(b, 1'b0);
    end
    chk("fullpop_before", {28'h0, Level}, 32'd8);
    sample_byte(8'h90, 1'b0);
    sample_byte(8'h91, 1'b1);
    chk("fullpop_level", {28'h0, Level}, 32'd8);
    chk("fullpop_ovf", {31'h0, Ovf}, 32'h0);
    for (int i = 0; i < 8; i++) idle(1'b1);
    idle(1'b0);
    chk("final_level", {28'h0, Level}, 32'd0);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
